// File: rtl/lp_pkg.sv
// Shared constants and FSM state type for the Zigbee post-demodulation
// boxcar low-pass / decimator.
package lp_pkg;

  localparam int DATA_W    = 7;
  localparam int TAPS      = 8;
  localparam int LOG2_TAPS = $clog2(TAPS);
  localparam int DECIM     = 2;
  localparam int ACC_W     = DATA_W + LOG2_TAPS;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } lp_state_t;

endpackage

// File: rtl/boxcar_channel.sv
// One channel of the moving-average filter: delay line, running sum and
// output register. The running sum is updated on every accepted sample.
module boxcar_channel #(
  parameter int DATA_W = lp_pkg::DATA_W,
  parameter int TAPS   = lp_pkg::TAPS
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     accept,
  input  logic                     emit,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);
  import lp_pkg::*;

  localparam int SH    = $clog2(TAPS);
  localparam int SUM_W = DATA_W + SH;

  // Arithmetic shift gives floor division; the mean of TAPS in-range
  // samples always fits back into DATA_W, so no saturation is needed.
  function automatic logic signed [DATA_W-1:0] shr_floor(
    input logic signed [SUM_W-1:0] s
  );
    logic signed [SUM_W-1:0] t;
    t = s >>> SH;
    return t[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] dly_p0 [TAPS];
  logic signed [SUM_W-1:0]  acc_p0;
  logic signed [SUM_W-1:0]  acc_nxt;

  always_comb acc_nxt = acc_p0 + SUM_W'(x) - SUM_W'(dly_p0[TAPS-1]);

  // Stage p0 -> output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_p0 <= '0;
      y      <= '0;
      for (int k = 0; k < TAPS; k++) dly_p0[k] <= '0;
    end else if (accept) begin
      acc_p0    <= acc_nxt;
      dly_p0[0] <= x;
      for (int k = 1; k < TAPS; k++) dly_p0[k] <= dly_p0[k-1];
      if (emit) y <= shr_floor(acc_nxt);
    end
  end

endmodule

// File: rtl/lowpass_decim.sv
// Boxcar low-pass on baseband I/Q followed by decimation; drives a one-cycle
// lp_rdy strobe alongside each new filtered sample.
module lowpass_decim #(
  parameter int DATA_W = lp_pkg::DATA_W,
  parameter int TAPS   = lp_pkg::TAPS,
  parameter int DECIM  = lp_pkg::DECIM
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic signed [DATA_W-1:0] I_BB,
  input  logic signed [DATA_W-1:0] Q_BB,
  input  logic                     demod_rdy,
  output logic signed [DATA_W-1:0] I_LP,
  output logic signed [DATA_W-1:0] Q_LP,
  output logic                     lp_rdy
);
  import lp_pkg::*;

  localparam int FILL_W = $clog2(TAPS);
  localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(TAPS - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
  // Phase after the first output; wraps straight to 0 when DECIM is 1.
  localparam logic [DEC_W-1:0]  DEC_FIRST = (DECIM > 1) ? DEC_W'(1) : '0;

  lp_state_t         state;
  lp_state_t         state_nxt;
  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_cnt_nxt;
  logic [DEC_W-1:0]  dec_cnt;
  logic [DEC_W-1:0]  dec_cnt_nxt;
  logic              emit_p0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= FILL;
      fill_cnt <= '0;
      dec_cnt  <= '0;
      lp_rdy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
      dec_cnt  <= dec_cnt_nxt;
      lp_rdy   <= emit_p0;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    dec_cnt_nxt  = dec_cnt;
    emit_p0      = 1'b0;
    if (demod_rdy) begin
      case (state)
        FILL: begin
          if (fill_cnt == FILL_LAST) begin
            emit_p0     = 1'b1;
            state_nxt   = RUN;
            dec_cnt_nxt = DEC_FIRST;
          end else begin
            fill_cnt_nxt = fill_cnt + 1'b1;
          end
        end
        RUN: begin
          emit_p0     = (dec_cnt == '0);
          dec_cnt_nxt = (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  // Stage p0 -> registered outputs (inside each channel)
  boxcar_channel #(.DATA_W(DATA_W), .TAPS(TAPS)) u_chan_i (
    .clk    (clk),
    .resetn (resetn),
    .accept (demod_rdy),
    .emit   (emit_p0),
    .x      (I_BB),
    .y      (I_LP)
  );

  boxcar_channel #(.DATA_W(DATA_W), .TAPS(TAPS)) u_chan_q (
    .clk    (clk),
    .resetn (resetn),
    .accept (demod_rdy),
    .emit   (emit_p0),
    .x      (Q_BB),
    .y      (Q_LP)
  );

endmodule

// File: tb/tb_lowpass_decim.sv
// Directed bench for lowpass_decim: one instance with DECIM=2 and one with
// DECIM=1 share the same stimulus.
module tb_lowpass_decim;

  logic                    clk;
  logic                    resetn;
  logic signed [6:0]       i_bb, q_bb;
  logic                    demod_rdy;
  logic signed [6:0]       i_lp1, q_lp1, i_lp2, q_lp2;
  logic                    rdy1, rdy2;

  int vecs  = 0;
  int fails = 0;

  // values captured by strobe()
  logic signed [6:0] i1, q1, i2, q2;
  logic              r1, r2, nx1, nx2;

  lowpass_decim #(.DATA_W(7), .TAPS(8), .DECIM(2)) u_dec2 (
    .clk(clk), .resetn(resetn), .I_BB(i_bb), .Q_BB(q_bb),
    .demod_rdy(demod_rdy), .I_LP(i_lp2), .Q_LP(q_lp2), .lp_rdy(rdy2)
  );

  lowpass_decim #(.DATA_W(7), .TAPS(8), .DECIM(1)) u_dec1 (
    .clk(clk), .resetn(resetn), .I_BB(i_bb), .Q_BB(q_bb),
    .demod_rdy(demod_rdy), .I_LP(i_lp1), .Q_LP(q_lp1), .lp_rdy(rdy1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic capture();
    r1 = rdy1; i1 = i_lp1; q1 = q_lp1;
    r2 = rdy2; i2 = i_lp2; q2 = q_lp2;
  endtask

  // One accepted sample, then idle so that strobes are 'gap' clocks apart.
  task automatic strobe(input logic signed [6:0] i, input logic signed [6:0] q,
                        input int gap);
    @(negedge clk);
    i_bb = i; q_bb = q; demod_rdy = 1'b1;
    @(posedge clk); #1;
    demod_rdy = 1'b0;
    capture();
    nx1 = 1'b0; nx2 = 1'b0;
    if (gap > 1) begin
      @(posedge clk); #1;
      nx1 = rdy1; nx2 = rdy2;
      repeat (gap - 2) @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    demod_rdy = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      i_bb = 7'($urandom); q_bb = 7'($urandom); demod_rdy = 1'($urandom);
      @(posedge clk); #1;
      vecs++;
      if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || i_lp1 !== 7'sd0 || q_lp1 !== 7'sd0 ||
          i_lp2 !== 7'sd0 || q_lp2 !== 7'sd0) begin
        fails++;
        $display("FAIL reset c=%0d got rdy %b/%b I %0d/%0d Q %0d/%0d exp all 0",
                 c, rdy1, rdy2, i_lp1, i_lp2, q_lp1, q_lp2);
      end
    end
    @(negedge clk);
    demod_rdy = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_constant();
    logic exp_r;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      strobe(7'sd40, -7'sd40, 5);
      exp_r = (k >= 8) && (((k - 8) % 2) == 0);
      vecs++;
      if (r2 !== exp_r || nx2 !== 1'b0) begin
        fails++;
        $display("FAIL const_rdy k=%0d got %b next %b exp %b next 0", k, r2, nx2, exp_r);
      end
      if (k >= 8) begin
        vecs++;
        if (i2 !== 7'sd40 || q2 !== -7'sd40) begin
          fails++;
          $display("FAIL const_val k=%0d got I %0d Q %0d exp I 40 Q -40", k, i2, q2);
        end
      end else begin
        vecs++;
        if (r1 !== 1'b0) begin
          fails++;
          $display("FAIL const_fill1 k=%0d got rdy %b exp 0", k, r1);
        end
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      strobe(7'sd63, -7'sd64, 5);
      if (k >= 8) begin
        vecs++;
        if (i2 !== 7'sd63 || q2 !== -7'sd64 || i1 !== 7'sd63 || q1 !== -7'sd64) begin
          fails++;
          $display("FAIL extreme k=%0d got I %0d/%0d Q %0d/%0d exp I 63 Q -64",
                   k, i1, i2, q1, q2);
        end
      end
    end
  endtask

  task automatic test_impulse();
    logic signed [6:0] ei, eq, xi, xq;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      xi = (k == 9) ? 7'sd56 : 7'sd0;
      xq = (k == 9) ? -7'sd1 : 7'sd0;
      strobe(xi, xq, 2);
      ei = (k >= 9 && k <= 16) ? 7'sd7 : 7'sd0;
      eq = (k >= 9 && k <= 16) ? -7'sd1 : 7'sd0;
      vecs++;
      if (r1 !== (k >= 8)) begin
        fails++;
        $display("FAIL impulse_rdy k=%0d got %b exp %b", k, r1, (k >= 8));
      end
      if (k >= 8) begin
        vecs++;
        if (i1 !== ei || q1 !== eq) begin
          fails++;
          $display("FAIL impulse_val k=%0d got I %0d Q %0d exp I %0d Q %0d",
                   k, i1, q1, ei, eq);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [6:0] ei, eq;
    logic              e2;
    do_reset();
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      i_bb = 7'(j); q_bb = 7'(-j); demod_rdy = 1'b1;
      @(posedge clk); #1;
      capture();
      e2 = (j >= 7) && (((j - 7) % 2) == 0);
      vecs++;
      if (r1 !== (j >= 7) || r2 !== e2) begin
        fails++;
        $display("FAIL b2b_rdy j=%0d got %b/%b exp %b/%b", j, r1, r2, (j >= 7), e2);
      end
      if (j >= 7) begin
        ei = 7'(j - 4);
        eq = 7'(3 - j);
        vecs++;
        if (i1 !== ei || q1 !== eq) begin
          fails++;
          $display("FAIL b2b_val j=%0d got I %0d Q %0d exp I %0d Q %0d",
                   j, i1, q1, ei, eq);
        end
      end
    end
    @(negedge clk);
    demod_rdy = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || i_lp1 !== 7'sd11 || q_lp1 !== -7'sd12) begin
      fails++;
      $display("FAIL b2b_idle got rdy %b/%b I %0d Q %0d exp rdy 0/0 I 11 Q -12",
               rdy1, rdy2, i_lp1, q_lp1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 20; k++) strobe(7'sd20, 7'sd20, 3);
    vecs++;
    if (i2 !== 7'sd20 || i1 !== 7'sd20) begin
      fails++;
      $display("FAIL midrst_pre got I %0d/%0d exp 20", i1, i2);
    end
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    vecs++;
    if (i_lp1 !== 7'sd0 || q_lp1 !== 7'sd0 || i_lp2 !== 7'sd0 || q_lp2 !== 7'sd0 ||
        rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async got I %0d/%0d Q %0d/%0d rdy %b/%b exp all 0",
               i_lp1, i_lp2, q_lp1, q_lp2, rdy1, rdy2);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      strobe(7'sd20, 7'sd20, 3);
      vecs++;
      if (k < 8) begin
        if (r1 !== 1'b0 || r2 !== 1'b0 || i1 !== 7'sd0) begin
          fails++;
          $display("FAIL midrst_fill k=%0d got rdy %b/%b I %0d exp rdy 0/0 I 0",
                   k, r1, r2, i1);
        end
      end else begin
        if (r1 !== 1'b1 || r2 !== 1'b1 || i1 !== 7'sd20 || i2 !== 7'sd20 ||
            q1 !== 7'sd20 || q2 !== 7'sd20) begin
          fails++;
          $display("FAIL midrst_first got rdy %b/%b I %0d/%0d Q %0d/%0d exp rdy 1/1 20",
                   r1, r2, i1, i2, q1, q2);
        end
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    demod_rdy = 1'b0;
    i_bb      = '0;
    q_bb      = '0;
    test_reset();
    test_constant();
    test_extremes();
    test_impulse();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/lowpass_decim.md
# lowpass_decim

Post-demodulation channel filter for the Zigbee receive path. Consumes the baseband I/Q samples and `demod_rdy` strobe produced by the `demodulation` block. Applies an identical TAPS-point moving-average (boxcar) low-pass to I and Q, decimates by DECIM, and presents filtered 7-bit samples with a one-cycle `lp_rdy` strobe to the downstream despreader/timing-recovery stage.

## Interface
- DATA_W, 7: signed sample width, input and output
- TAPS, 8: boxcar length; power of two, ≥2
- DECIM, 2: decimation ratio, ≥1
- clk  in  1  system clock, 50 MHz
- resetn  in  1  reset; one clock, reset is asynchronous and active-low
- I_BB  in  DATA_W  signed baseband I from demodulator
- Q_BB  in  DATA_W  signed baseband Q from demodulator
- demod_rdy  in  1  input sample strobe; I_BB/Q_BB valid when high
- I_LP  out  DATA_W  signed filtered, decimated I
- Q_LP  out  DATA_W  signed filtered, decimated Q
- lp_rdy  out  1  one-cycle strobe; I_LP/Q_LP updated this cycle

## Operation
- Every rising edge with `demod_rdy`=1 is one accepted sample. There is no backpressure and no minimum spacing; consecutive high cycles are consecutive samples.
- Per channel: TAPS-deep delay line plus running accumulator, ACC_W = DATA_W+log2(TAPS) bits signed. On accept: acc ← acc + x_new − x_oldest; shift x_new in; drop x_oldest.
- Output value = (acc after update) >>> log2(TAPS): arithmetic shift, floor rounding (−1/8 → −1). Range is always within DATA_W signed, so no saturation logic is required.
- Control FSM, two states:
  - FILL (reset state): fill_cnt counts accepted samples 0..TAPS−1. No `lp_rdy`. When a sample is accepted with fill_cnt=TAPS−1: emit output, move to RUN, dec_cnt←1 (wraps to 0 if DECIM=1).
  - RUN: each accept increments dec_cnt modulo DECIM. Emit output when dec_cnt=0 before the increment. FILL is re-entered only by reset.
- Emit = register I_LP/Q_LP from the updated accumulators and pulse `lp_rdy`. Between emits, I_LP/Q_LP hold their value.
- The delay line and accumulator update on every accept in both states, including non-emitting samples.

## Timing
- Reset (async assert, sync-to-clk deassert expected upstream): I_LP=0, Q_LP=0, lp_rdy=0, accumulators=0, delay lines=0, fill_cnt=0, dec_cnt=0, state=FILL.
- Latency 1 clock: `demod_rdy` sampled high at edge k drives `lp_rdy`=1 and the new I_LP/Q_LP from edge k, valid for exactly the cycle k..k+1.
- `lp_rdy` is never high for two consecutive cycles when DECIM≥2. With DECIM=1 and back-to-back `demod_rdy`, `lp_rdy` may stay high for consecutive cycles (one pulse per sample).
- Reset asserted mid-operation: all state clears immediately. The first `lp_rdy` after release requires TAPS new samples; no pre-reset samples contribute.
- `demod_rdy` low: no state changes anywhere.

## Structure
- Package `lp_pkg`: DATA_W, TAPS, LOG2_TAPS, DECIM, ACC_W localparams and `lp_state_t` enum {FILL, RUN}.
- Sub-module `boxcar_channel` holds delay line, accumulator, and output register for one channel. It has inputs clk, resetn, accept, emit, x. It is instantiated twice, for I and Q.
- Top `lowpass_decim` holds the FSM, fill_cnt, dec_cnt, and `lp_rdy`.

## Test plan
- Reset: hold resetn=0 with random I_BB/Q_BB and demod_rdy toggling → I_LP=Q_LP=0, lp_rdy=0 throughout.
- Constant input, TAPS=8, DECIM=2, strobe every 5 clocks (as the demodulator produces): I=+40, Q=−40 → no lp_rdy for strobes 1–7. Strobe 8 → lp_rdy, I_LP=40, Q_LP=−40. Then lp_rdy on strobes 10, 12, 14…
- Extremes: I=+63, Q=−64 for 16 strobes → I_LP=63, Q_LP=−64, no wrap.
- Impulse/rounding, DECIM=1: 8 zeros, then I=56 once, then zeros → I_LP=7 for 8 outputs, then 0. Q=−1 once → Q_LP=−1 for 8 outputs (floor), then 0.
- Back-to-back: demod_rdy high 16 consecutive cycles with I ramp 0..15, DECIM=1 → first lp_rdy after the 8th cycle with I_LP=3 (28>>>3). Subsequent outputs are floor((sum of last 8)/8) each cycle.
- Reset mid-run: after 20 strobes of I=20, pulse resetn low 3 cycles → outputs 0 immediately. Next lp_rdy only at the 8th post-reset strobe, with value 20.
